// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush scheduler.
// Control bundles are ordered {enables pc..mem_wb, flushes if_id..ex_mem}.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        JUMP_FLUSH = 2'd1,
        EX_WAIT    = 2'd2
    } state_e;

    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic id_ex_we;
        logic ex_mem_we;
        logic mem_wb_we;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
    } pipe_ctl_t;

    localparam pipe_ctl_t PIPE_RUN  = 8'b11111_000;
    localparam pipe_ctl_t PIPE_HOLD = 8'b00000_000;
    localparam pipe_ctl_t PIPE_LOAD = 8'b00111_010;
    localparam pipe_ctl_t PIPE_MDU  = 8'b00011_001;
    localparam pipe_ctl_t PIPE_JUMP = 8'b11111_100;

    function automatic logic [1:0] flush_count(input pipe_ctl_t c);
        return {1'b0, c.if_id_flush} + {1'b0, c.id_ex_flush} + {1'b0, c.ex_mem_flush};
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard/handshake inputs and pipeline control outputs of the scheduler.
// The master side is the scheduler itself; the slave side is the pipeline.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             load_stall;
    logic             jump_stall;
    logic             mdu_op_ID_EX;
    logic             mdu_done;
    logic             dmem_req_EX_MEM;
    logic             dmem_ready;

    logic             pc_we;
    logic             if_id_we;
    logic             id_ex_we;
    logic             ex_mem_we;
    logic             mem_wb_we;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic             mdu_start;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] bubble_count;

    modport master (
        input  load_stall, jump_stall, mdu_op_ID_EX, mdu_done,
               dmem_req_EX_MEM, dmem_ready,
        output pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
               if_id_flush, id_ex_flush, ex_mem_flush, mdu_start,
               stall_cycles, bubble_count
    );

    modport slave (
        output load_stall, jump_stall, mdu_op_ID_EX, mdu_done,
               dmem_req_EX_MEM, dmem_ready,
        input  pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
               if_id_flush, id_ex_flush, ex_mem_flush, mdu_start,
               stall_cycles, bubble_count
    );

endinterface

// File: rtl/perf_counter.sv
// Wrapping performance counter that adds 0..3 per cycle.
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(i_inc);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush scheduler: Mealy control from a small FSM covering multi-cycle
// jump penalties and MDU waits, plus stall-cycle and bubble counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int JUMP_PENALTY = 1,
    parameter int CNT_W        = 32
) (
    input  logic            clk,
    input  logic            rst,
    pipeline_ctrl_if.master bus
);

    localparam int PEN_W = $clog2(JUMP_PENALTY + 1);

    localparam logic [1:0] S_RUN        = RUN;
    localparam logic [1:0] S_JUMP_FLUSH = JUMP_FLUSH;
    localparam logic [1:0] S_EX_WAIT    = EX_WAIT;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [PEN_W-1:0] r_pen_cnt;
    logic [PEN_W-1:0] w_next_pen;
    pipe_ctl_t        w_ctl;
    logic             w_start;
    logic             w_freeze;

    assign w_freeze = bus.dmem_req_EX_MEM & ~bus.dmem_ready;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_ctl        = PIPE_RUN;
        w_start      = 1'b0;
        w_next_state = r_state;
        w_next_pen   = r_pen_cnt;

        // A stalled memory access freezes the whole pipe and the FSM with it.
        if (rst || w_freeze) begin
            w_ctl = PIPE_HOLD;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (bus.mdu_op_ID_EX) begin
                        w_ctl        = PIPE_MDU;
                        w_start      = 1'b1;
                        w_next_state = S_EX_WAIT;
                    end else if (bus.load_stall) begin
                        w_ctl = PIPE_LOAD;
                    end else if (bus.jump_stall) begin
                        w_ctl = PIPE_JUMP;
                        if (JUMP_PENALTY > 1) begin
                            w_next_pen   = PEN_W'(JUMP_PENALTY - 1);
                            w_next_state = S_JUMP_FLUSH;
                        end
                    end
                end
                S_JUMP_FLUSH: begin
                    w_ctl      = PIPE_JUMP;
                    w_next_pen = r_pen_cnt - PEN_W'(1);
                    if (r_pen_cnt == PEN_W'(1)) begin
                        w_next_state = S_RUN;
                    end
                end
                S_EX_WAIT: begin
                    if (bus.mdu_done) begin
                        w_next_state = S_RUN;
                    end else begin
                        w_ctl = PIPE_MDU;
                    end
                end
                default: begin
                    w_next_state = S_RUN;
                    w_next_pen   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_RUN;
            r_pen_cnt <= '0;
        end else begin
            r_state   <= w_next_state;
            r_pen_cnt <= w_next_pen;
        end
    end

    assign bus.pc_we        = w_ctl.pc_we;
    assign bus.if_id_we     = w_ctl.if_id_we;
    assign bus.id_ex_we     = w_ctl.id_ex_we;
    assign bus.ex_mem_we    = w_ctl.ex_mem_we;
    assign bus.mem_wb_we    = w_ctl.mem_wb_we;
    assign bus.if_id_flush  = w_ctl.if_id_flush;
    assign bus.id_ex_flush  = w_ctl.id_ex_flush;
    assign bus.ex_mem_flush = w_ctl.ex_mem_flush;
    assign bus.mdu_start    = w_start;

    perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   ({1'b0, ~w_ctl.pc_we}),
        .o_count (bus.stall_cycles)
    );

    perf_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (flush_count(w_ctl)),
        .o_count (bus.bubble_count)
    );

endmodule
